// File: rtl/bpu_update_sched_pkg.sv
// Shared types for the BTB update scheduler: FSM encoding, queued update
// entry layout, and the slot-index width derivation.
package bpu_update_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
   } upd_entry_t;

   localparam int ENTRY_W = $bits(upd_entry_t);

   // Index width for a power-of-two slot count; never narrower than one bit.
   function automatic int iw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bpu_update_sched_if.sv
// Bundles for the scheduler: the EX-side update bus and the BTB probe/write port.

// EX branch-resolution update bus. master = EX, slave = scheduler.
interface bpu_upd_if;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_ready;
   logic        stall_req;

   modport master (output upd_valid, upd_pc, upd_target, upd_taken,
                   input  upd_ready, stall_req);
   modport slave  (input  upd_valid, upd_pc, upd_target, upd_taken,
                   output upd_ready, stall_req);
endinterface

// BTB tag probe and write port. master = scheduler, slave = BTB.
interface bpu_btb_if #(parameter int IW = 3);
   logic [31:0]   btb_probe_pc;
   logic          btb_probe_hit;
   logic [IW-1:0] btb_probe_idx;
   logic          btb_wr_ready;
   logic          btb_wr_en;
   logic [IW-1:0] btb_wr_idx;
   logic          btb_wr_valid;
   logic [31:0]   btb_wr_pc;
   logic [31:0]   btb_wr_target;

   modport master (output btb_probe_pc, btb_wr_en, btb_wr_idx, btb_wr_valid,
                          btb_wr_pc, btb_wr_target,
                   input  btb_probe_hit, btb_probe_idx, btb_wr_ready);
   modport slave  (input  btb_probe_pc, btb_wr_en, btb_wr_idx, btb_wr_valid,
                          btb_wr_pc, btb_wr_target,
                   output btb_probe_hit, btb_probe_idx, btb_wr_ready);
endinterface

// File: rtl/bpu_upd_fifo.sv
// Circular update queue. A push whose PC matches the most recent push
// overwrites that tail entry instead of taking a new slot.
module bpu_upd_fifo
   import bpu_update_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  upd_entry_t             push_entry,
   output upd_entry_t             head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d, tail_q, tail_d, last_ptr;
   logic [CW-1:0] count_q, count_d;
   upd_entry_t    mem_q [DEPTH];
   upd_entry_t    mem_d [DEPTH];
   logic          coalesce, push_new;

   // Pointer/count update and coalesce decision. The tail entry is not
   // coalesced into when it is also the head leaving the queue this cycle.
   always_comb begin
      last_ptr = tail_q - PW'(1);
      coalesce = push && (count_q != '0) && (push_entry.pc == mem_q[last_ptr].pc)
                 && !(pop && (count_q == CW'(1)));
      push_new = push && !coalesce;
      mem_d    = mem_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (coalesce) begin
            mem_d[last_ptr] = push_entry;
         end else if (push_new) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + PW'(1);
         end
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         case ({push_new, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless while count is zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[head_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/bpu_update_sched.sv
// BTB update scheduler: queues resolved branches, drains them one write per
// cycle into the BTB, and walks the BTB for a full invalidate on request.
//
//   state    | meaning
//   ST_IDLE  | queue empty, no BTB traffic
//   ST_DRAIN | head entry probed and written (or skipped) into the BTB
//   ST_CLEAR | invalidation walk over every BTB slot, queue discarded
module bpu_update_sched
   import bpu_update_sched_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int BTB_ENTRIES = 8
) (
   input  logic       clk,
   input  logic       rst,
   bpu_upd_if.slave   upd,
   input  logic       inv_all,
   bpu_btb_if.master  btb,
   output logic       busy
);
   localparam int IW = iw_of(BTB_ENTRIES);
   localparam int CW = $clog2(DEPTH) + 1;

   sched_state_e  state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d, clr_idx_q, clr_idx_d;
   logic          push, pop, upd_ready, stall_req;
   upd_entry_t    head, push_entry;
   logic [CW-1:0] count;
   logic          full;
   logic          wr_en, wr_valid;
   logic [IW-1:0] wr_idx;
   logic [31:0]   wr_pc, wr_target, probe_pc;

   assign push_entry = '{pc: upd.upd_pc, target: upd.upd_target, taken: upd.upd_taken};

   bpu_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (inv_all),
      .push       (push),
      .pop        (pop),
      .push_entry (push_entry),
      .head       (head),
      .count      (count),
      .full       (full)
   );

   // Next-state, queue handshake and BTB write port decode.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      clr_idx_d = clr_idx_q;
      pop       = 1'b0;
      wr_en     = 1'b0;
      wr_valid  = 1'b0;
      wr_idx    = '0;
      wr_pc     = '0;
      wr_target = '0;
      probe_pc  = '0;
      upd_ready = !full && (state_q != ST_CLEAR);
      push      = upd.upd_valid && upd_ready && !inv_all;
      stall_req = upd.upd_valid && !upd_ready && !inv_all;
      case (state_q)
         ST_IDLE: begin
            if (inv_all) begin
               state_d   = ST_CLEAR;
               clr_idx_d = '0;
            end else if ((count != '0) || push) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            probe_pc = head.pc;
            if (inv_all) begin
               state_d   = ST_CLEAR;
               clr_idx_d = '0;
            end else begin
               if (head.taken || btb.btb_probe_hit) begin
                  wr_en     = btb.btb_wr_ready;
                  wr_valid  = head.taken;
                  wr_pc     = head.pc;
                  wr_target = head.target;
                  wr_idx    = btb.btb_probe_hit ? btb.btb_probe_idx : rr_ptr_q;
                  pop       = btb.btb_wr_ready;
                  if (btb.btb_wr_ready && !btb.btb_probe_hit) begin
                     rr_ptr_d = rr_ptr_q + IW'(1);
                  end
               end else begin
                  pop = 1'b1;
               end
               if (pop && (count == CW'(1)) && !push) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_CLEAR: begin
            if (inv_all) begin
               clr_idx_d = '0;
            end else if (btb.btb_wr_ready) begin
               wr_en  = 1'b1;
               wr_idx = clr_idx_q;
               if (clr_idx_q == IW'(BTB_ENTRIES - 1)) begin
                  clr_idx_d = '0;
                  rr_ptr_d  = '0;
                  state_d   = ST_IDLE;
               end else begin
                  clr_idx_d = clr_idx_q + IW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Every write field reads zero while no write is strobed.
      if (!wr_en) begin
         wr_valid  = 1'b0;
         wr_idx    = '0;
         wr_pc     = '0;
         wr_target = '0;
      end
   end

   // State, replacement pointer and clear-walk index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   assign upd.upd_ready     = upd_ready;
   assign upd.stall_req     = stall_req;
   assign btb.btb_probe_pc  = probe_pc;
   assign btb.btb_wr_en     = wr_en;
   assign btb.btb_wr_idx    = wr_idx;
   assign btb.btb_wr_valid  = wr_valid;
   assign btb.btb_wr_pc     = wr_pc;
   assign btb.btb_wr_target = wr_target;
   assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bpu_update_sched.sv
// Directed bench for bpu_update_sched: drain, coalesce, stall, invalidate walk.
module tb_bpu_update_sched;
   logic clk = 1'b0;
   logic rst;
   logic inv_all;
   logic busy;
   int   total = 0;
   int   bad   = 0;

   bpu_upd_if              u_upd ();
   bpu_btb_if #(.IW(3))    u_btb ();

   bpu_update_sched #(.DEPTH(4), .BTB_ENTRIES(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .upd     (u_upd),
      .inv_all (inv_all),
      .btb     (u_btb),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      u_upd.upd_valid  = v;
      u_upd.upd_pc     = pc;
      u_upd.upd_target = tgt;
      u_upd.upd_taken  = tk;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [2:0] idx,
                         input logic vld, input logic [31:0] pc, input logic [31:0] tgt);
      chk({tag, "_en"},  32'(u_btb.btb_wr_en), 32'(en));
      chk({tag, "_idx"}, 32'(u_btb.btb_wr_idx), 32'(idx));
      chk({tag, "_vld"}, 32'(u_btb.btb_wr_valid), 32'(vld));
      chk({tag, "_pc"},  u_btb.btb_wr_pc, pc);
      chk({tag, "_tgt"}, u_btb.btb_wr_target, tgt);
   endtask

   initial begin
      rst = 1'b1;
      inv_all = 1'b0;
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      u_btb.btb_probe_hit = 1'b0;
      u_btb.btb_probe_idx = 3'd0;
      u_btb.btb_wr_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      // reset state
      chk_wr("rst", 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
      chk("rst_ready", 32'(u_upd.upd_ready), 32'd1);
      chk("rst_stall", 32'(u_upd.stall_req), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_probe", u_btb.btb_probe_pc, 32'h0);

      // single taken miss, written the cycle after enqueue at rr slot 0
      u_btb.btb_wr_ready = 1'b1;
      upd(1'b1, 32'h1000, 32'h2000, 1'b1);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk_wr("t1", 1'b1, 3'd0, 1'b1, 32'h1000, 32'h2000);
      chk("t1_probe", u_btb.btb_probe_pc, 32'h1000);
      chk("t1_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_idle", 32'(busy), 32'd0);
      chk("t1_noen", 32'(u_btb.btb_wr_en), 32'd0);
      // rr_ptr advanced to 1
      upd(1'b1, 32'h1100, 32'h2100, 1'b1);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk_wr("t1b", 1'b1, 3'd1, 1'b1, 32'h1100, 32'h2100);
      tick();

      // fill to full with write port blocked, then drain
      do_reset();
      u_btb.btb_wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         upd(1'b1, 32'h100 + 32'(i * 4), 32'h900 + 32'(i), 1'b1);
         #1;
         chk("t2_ready", 32'(u_upd.upd_ready), 32'd1);
         chk("t2_stall", 32'(u_upd.stall_req), 32'd0);
         chk("t2_blocked", 32'(u_btb.btb_wr_en), 32'd0);
         tick();
      end
      upd(1'b1, 32'h110, 32'h904, 1'b1);
      #1;
      chk("t2_full_ready", 32'(u_upd.upd_ready), 32'd0);
      chk("t2_full_stall", 32'(u_upd.stall_req), 32'd1);
      chk("t2_probe", u_btb.btb_probe_pc, 32'h100);
      u_btb.btb_wr_ready = 1'b1;
      #1;
      chk("t2_nobypass", 32'(u_upd.stall_req), 32'd1);
      chk_wr("t2_w0", 1'b1, 3'd0, 1'b1, 32'h100, 32'h900);
      tick();
      chk("t2_reopen", 32'(u_upd.upd_ready), 32'd1);
      chk("t2_unstall", 32'(u_upd.stall_req), 32'd0);
      chk_wr("t2_w1", 1'b1, 3'd1, 1'b1, 32'h104, 32'h901);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk_wr("t2_w2", 1'b1, 3'd2, 1'b1, 32'h108, 32'h902);
      tick();
      chk_wr("t2_w3", 1'b1, 3'd3, 1'b1, 32'h10c, 32'h903);
      tick();
      chk_wr("t2_w4", 1'b1, 3'd4, 1'b1, 32'h110, 32'h904);
      tick();
      chk("t2_idle", 32'(busy), 32'd0);

      // coalesce two updates to the same PC
      do_reset();
      u_btb.btb_wr_ready = 1'b0;
      upd(1'b1, 32'h1000, 32'h2000, 1'b1);
      tick();
      upd(1'b1, 32'h1000, 32'h3000, 1'b1);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      u_btb.btb_wr_ready = 1'b1;
      #1;
      chk_wr("t3_w", 1'b1, 3'd0, 1'b1, 32'h1000, 32'h3000);
      tick();
      chk("t3_single", 32'(busy), 32'd0);
      chk("t3_noen", 32'(u_btb.btb_wr_en), 32'd0);

      // not-taken hit invalidates at the hit slot
      do_reset();
      upd(1'b1, 32'h1000, 32'h2000, 1'b0);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      u_btb.btb_probe_hit = 1'b1;
      u_btb.btb_probe_idx = 3'd5;
      #1;
      chk_wr("t4_nthit", 1'b1, 3'd5, 1'b0, 32'h1000, 32'h2000);
      tick();
      chk("t4_idle", 32'(busy), 32'd0);
      // not-taken miss pops without a write, port blocked
      u_btb.btb_probe_hit = 1'b0;
      u_btb.btb_wr_ready  = 1'b0;
      upd(1'b1, 32'h1400, 32'h2400, 1'b0);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("t4_ntmiss_en", 32'(u_btb.btb_wr_en), 32'd0);
      chk("t4_ntmiss_busy", 32'(busy), 32'd1);
      tick();
      chk("t4_ntmiss_pop", 32'(busy), 32'd0);
      // taken hit uses hit slot and leaves rr_ptr at 0
      u_btb.btb_wr_ready  = 1'b1;
      upd(1'b1, 32'h1800, 32'h2800, 1'b1);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      u_btb.btb_probe_hit = 1'b1;
      u_btb.btb_probe_idx = 3'd6;
      #1;
      chk_wr("t4_thit", 1'b1, 3'd6, 1'b1, 32'h1800, 32'h2800);
      tick();
      u_btb.btb_probe_hit = 1'b0;
      upd(1'b1, 32'h1c00, 32'h2c00, 1'b1);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk_wr("t4_rr0", 1'b1, 3'd0, 1'b1, 32'h1c00, 32'h2c00);
      tick();

      // invalidate during drain: queue dropped, full walk, rr_ptr back to 0
      do_reset();
      u_btb.btb_wr_ready = 1'b1;
      upd(1'b1, 32'h3000, 32'h4000, 1'b1);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      u_btb.btb_wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         upd(1'b1, 32'h3100 + 32'(i * 4), 32'h4100, 1'b1);
         tick();
      end
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      inv_all = 1'b1;
      u_btb.btb_wr_ready = 1'b1;
      #1;
      chk("t5_suppress", 32'(u_btb.btb_wr_en), 32'd0);
      tick();
      inv_all = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         chk_wr("t5_clr", 1'b1, 3'(i), 1'b0, 32'h0, 32'h0);
         chk("t5_busy", 32'(busy), 32'd1);
         chk("t5_ready", 32'(u_upd.upd_ready), 32'd0);
         tick();
      end
      chk("t5_done", 32'(busy), 32'd0);
      chk("t5_ready_back", 32'(u_upd.upd_ready), 32'd1);
      tick();
      chk("t5_dropped", 32'(busy), 32'd0);
      upd(1'b1, 32'h3800, 32'h4800, 1'b1);
      tick();
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk_wr("t5_rr0", 1'b1, 3'd0, 1'b1, 32'h3800, 32'h4800);
      tick();

      // invalidate wins over a same-cycle update; restart and reset mid-walk
      do_reset();
      inv_all = 1'b1;
      upd(1'b1, 32'h5000, 32'h6000, 1'b1);
      #1;
      chk("t6_stall", 32'(u_upd.stall_req), 32'd0);
      tick();
      inv_all = 1'b0;
      upd(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk_wr("t6_c0", 1'b1, 3'd0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      chk_wr("t6_c2", 1'b1, 3'd2, 1'b0, 32'h0, 32'h0);
      inv_all = 1'b1;
      #1;
      chk("t6_restart_en", 32'(u_btb.btb_wr_en), 32'd0);
      tick();
      inv_all = 1'b0;
      #1;
      chk_wr("t6_r0", 1'b1, 3'd0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      tick();
      chk_wr("t6_c3", 1'b1, 3'd3, 1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_rst_en", 32'(u_btb.btb_wr_en), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      tick();
      chk("t6_lost", 32'(busy), 32'd0);
      chk("t6_lost_en", 32'(u_btb.btb_wr_en), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
